memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage directly upstream of writeback in the 16-bit core.
- Takes execute-stage results and performs data-memory loads and stores over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Presents registered write-back info (enable, result, destination index, instr, pc) to the writeback stage.

Parameters:
- PMEM_WORD_WIDTH, 16, instruction word width
- PC_WIDTH, 12, program counter width
- IALU_WORD_WIDTH, 16, ALU result / register word width
- REG_IDX_WIDTH, 4, register index width
- DMEM_ADDR_WIDTH, 12, data memory address width
- DMEM_WORD_WIDTH, 16, data memory word width (must equal IALU_WORD_WIDTH)
- TIMEOUT_CYCLES, 255, wait-cycle limit (used only with optional feature)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_instr  in  PMEM_WORD_WIDTH  instruction word
- in_pc  in  PC_WIDTH  instruction pc
- in_res  in  IALU_WORD_WIDTH  ALU result; memory address for load/store
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register
- in_act_write_res_to_reg  in  1  instruction writes a register
- in_act_load  in  1  instruction is a load
- in_act_store  in  1  instruction is a store
- in_store_data  in  IALU_WORD_WIDTH  store data
- out_stall  out  1  upstream must hold its outputs
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DMEM_ADDR_WIDTH  memory address
- dmem_wdata  out  DMEM_WORD_WIDTH  write data
- dmem_ack  in  1  memory completes the access this cycle
- dmem_rdata  in  DMEM_WORD_WIDTH  read data, valid with dmem_ack
- out_valid  out  1  writeback info valid (one-cycle pulse per instruction)
- out_instr  out  PMEM_WORD_WIDTH  registered instr
- out_pc  out  PC_WIDTH  registered pc
- out_act_write_res_to_reg  out  1  register write enable to writeback
- out_res  out  IALU_WORD_WIDTH  ALU result or load data
- out_res_reg_idx  out  REG_IDX_WIDTH  destination register

Behaviour:
- Reset: at the sampling edge with reset=1, state=IDLE and every output register is cleared to 0: out_valid, out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc, dmem_req, dmem_we, dmem_addr, dmem_wdata. out_stall is 0 in IDLE.
- FSM states:
  - IDLE: accepts input.
  - WAIT: access outstanding.
- IDLE, in_valid=1, no load/store:
  - Next edge: out_valid=1 and out_* take the inputs.
  - Latency is 1 cycle; state stays IDLE.
- IDLE, in_valid=1, load or store:
  - Next edge: state=WAIT, dmem_req=1, dmem_addr=in_res[DMEM_ADDR_WIDTH-1:0] (upper bits truncated).
  - dmem_we=1 for a store, 0 for a load; dmem_wdata=in_store_data.
  - instr, pc, reg_idx and act flags are captured internally; out_valid=0.
- Load and store both set: treated as a load; the store is ignored.
- IDLE, in_valid=0: out_valid=0 and out_act_write_res_to_reg=0 next edge. Other out_* hold their values.
- WAIT:
  - out_stall=1 (combinational from state); in_valid and inputs are ignored.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until ack.
- WAIT, dmem_ack=1, next edge:
  - state=IDLE, dmem_req=0, out_valid=1, captured instr/pc/reg_idx are driven out.
  - Load: out_res=dmem_rdata and out_act_write_res_to_reg = captured flag.
  - Store: out_act_write_res_to_reg=0 and out_res=captured address word.
- Access timing:
  - Zero-wait load (ack in first WAIT cycle): 2 cycles from accept to out_valid.
  - Each extra wait cycle adds 1.
  - A new instruction can be accepted in the cycle after the ack edge.
- dmem_ack in IDLE is ignored.
- out_valid=0 forces out_act_write_res_to_reg=0; writeback never sees a stale enable.
- Reset during WAIT: return to IDLE and clear dmem_req at that edge; no out_valid pulse. A late dmem_ack after reset is ignored.

Optional Feature:
- Macro: MEMORY_ACCESS_TIMEOUT_EN.
- Defined:
  - Adds an 8-bit wait counter: cleared on entry to WAIT, incremented each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: abort, state=IDLE, dmem_req=0, out_valid=1, out_act_write_res_to_reg=0.
  - Sticky output port out_bus_error (1 bit) is set; it is cleared only by reset (reset value 0).
  - An ack on the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter and no out_bus_error port; WAIT lasts until dmem_ack, unbounded.

Test Plan:
- ALU op: in_valid=1, res=16'h1234, idx=3, write=1 -> next cycle out_valid=1, out_res=16'h1234, out_res_reg_idx=3, out_act_write_res_to_reg=1; dmem_req stays 0.
- Zero-wait load: in_res=16'hF0A5, idx=5, ack in first WAIT cycle with rdata=16'hBEEF -> dmem_addr=12'h0A5, dmem_we=0, out_stall=1 for 1 cycle, out_res=16'hBEEF, write=1 two cycles after accept.
- Store with 3 wait cycles: addr=16'h0010, data=16'h5555 -> dmem_we=1, dmem_wdata=16'h5555 stable 4 cycles, out_stall=1 for 4 cycles, then out_valid=1, out_act_write_res_to_reg=0.
- Back-to-back: load followed by an ALU op held during stall -> ALU op output exactly one cycle after load output; no instruction lost or duplicated.
- Reset asserted in the 2nd WAIT cycle, ack 1 cycle later -> dmem_req=0 after reset edge, out_valid never pulses, all outputs 0.
- With MEMORY_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> abort after 4 WAIT cycles, out_bus_error=1 sticky, out_act_write_res_to_reg=0.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access pipeline stage: performs data-memory loads/stores over a req/ack
// handshake and presents registered write-back info. Optional timeout: MEMORY_ACCESS_TIMEOUT_EN.
module memory_access #(
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int PC_WIDTH        = 12,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_act_write_res_to_reg,
  input  logic                       in_act_load,
  input  logic                       in_act_store,
  input  logic [IALU_WORD_WIDTH-1:0] in_store_data,
  output logic                       out_stall,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] dmem_wdata,
  input  logic                       dmem_ack,
  input  logic [DMEM_WORD_WIDTH-1:0] dmem_rdata,
  output logic                       out_valid,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
`ifdef MEMORY_ACCESS_TIMEOUT_EN
  ,
  output logic                       out_bus_error
`endif
);

  if (DMEM_WORD_WIDTH != IALU_WORD_WIDTH || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
  begin : g_param_check
    $error("memory_access: invalid parameter combination");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;

  logic                       is_mem;
  logic [PMEM_WORD_WIDTH-1:0] cap_instr;
  logic [PC_WIDTH-1:0]        cap_pc;
  logic [IALU_WORD_WIDTH-1:0] cap_res;
  logic [REG_IDX_WIDTH-1:0]   cap_idx;
  logic                       cap_write;
  logic                       cap_load;
  logic                       timeout_hit;

  assign is_mem = in_act_load | in_act_store;

`ifdef MEMORY_ACCESS_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // The abort fires on the edge that ends the TIMEOUT_CYCLES-th ack-less WAIT cycle
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt      <= '0;
      out_bus_error <= 1'b0;
    end else if (state_q == IDLE) begin
      wait_cnt <= '0;
    end else if (!dmem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
      if (timeout_hit) out_bus_error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_stall = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid && is_mem) state_d = WAIT;
      WAIT: begin
        out_stall = 1'b1;
        if (dmem_ack || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load wins over store when both flags are set; captured info is replayed on completion
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid                <= 1'b0;
      out_act_write_res_to_reg <= 1'b0;
      out_res                  <= '0;
      out_res_reg_idx          <= '0;
      out_instr                <= '0;
      out_pc                   <= '0;
      dmem_req                 <= 1'b0;
      dmem_we                  <= 1'b0;
      dmem_addr                <= '0;
      dmem_wdata               <= '0;
      cap_instr                <= '0;
      cap_pc                   <= '0;
      cap_res                  <= '0;
      cap_idx                  <= '0;
      cap_write                <= 1'b0;
      cap_load                 <= 1'b0;
    end else if (state_q == IDLE) begin
      out_valid                <= 1'b0;
      out_act_write_res_to_reg <= 1'b0;
      if (in_valid && is_mem) begin
        dmem_req   <= 1'b1;
        dmem_we    <= in_act_store & ~in_act_load;
        dmem_addr  <= in_res[DMEM_ADDR_WIDTH-1:0];
        dmem_wdata <= in_store_data;
        cap_instr  <= in_instr;
        cap_pc     <= in_pc;
        cap_res    <= in_res;
        cap_idx    <= in_res_reg_idx;
        cap_write  <= in_act_write_res_to_reg;
        cap_load   <= in_act_load;
      end else if (in_valid) begin
        out_valid                <= 1'b1;
        out_act_write_res_to_reg <= in_act_write_res_to_reg;
        out_res                  <= in_res;
        out_res_reg_idx          <= in_res_reg_idx;
        out_instr                <= in_instr;
        out_pc                   <= in_pc;
      end
    end else if (dmem_ack || timeout_hit) begin
      dmem_req        <= 1'b0;
      out_valid       <= 1'b1;
      out_instr       <= cap_instr;
      out_pc          <= cap_pc;
      out_res_reg_idx <= cap_idx;
      if (dmem_ack && cap_load) begin
        out_res                  <= dmem_rdata;
        out_act_write_res_to_reg <= cap_write;
      end else begin
        out_res                  <= cap_res;
        out_act_write_res_to_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases plus randomized traffic
// against a transaction-level expectation of each instruction's write-back.
module tb_memory_access;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic [11:0] in_pc = '0;
  logic [15:0] in_res = '0;
  logic [3:0]  in_res_reg_idx = '0;
  logic        in_act_write_res_to_reg = 1'b0;
  logic        in_act_load = 1'b0;
  logic        in_act_store = 1'b0;
  logic [15:0] in_store_data = '0;
  logic        out_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic        out_act_write_res_to_reg;
  logic [15:0] out_res;
  logic [3:0]  out_res_reg_idx;
`ifdef MEMORY_ACCESS_TIMEOUT_EN
  logic        out_bus_error;
`endif

  int vectors = 0;
  int miscompares = 0;

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_res(in_res),
    .in_res_reg_idx(in_res_reg_idx), .in_act_write_res_to_reg(in_act_write_res_to_reg),
    .in_act_load(in_act_load), .in_act_store(in_act_store), .in_store_data(in_store_data),
    .out_stall(out_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_act_write_res_to_reg(out_act_write_res_to_reg), .out_res(out_res),
    .out_res_reg_idx(out_res_reg_idx)
`ifdef MEMORY_ACCESS_TIMEOUT_EN
    , .out_bus_error(out_bus_error)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] instr, input logic [11:0] pc,
                               input logic [15:0] res, input logic [3:0] idx, input logic wr,
                               input logic ld, input logic st, input logic [15:0] sdata);
    in_valid = valid; in_instr = instr; in_pc = pc; in_res = res; in_res_reg_idx = idx;
    in_act_write_res_to_reg = wr; in_act_load = ld; in_act_store = st; in_store_data = sdata;
  endtask

  // What writeback should see for one instruction, straight from the stage's rules
  function automatic logic [15:0] expectRes(input logic ld, input logic [15:0] res,
                                            input logic [15:0] rdata);
    return ld ? rdata : res;
  endfunction

  function automatic logic expectWrite(input logic ld, input logic st, input logic wr);
    return (st && !ld) ? 1'b0 : wr;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_act"}, 32'(out_act_write_res_to_reg), 32'd0);
    checkOutput({tag, "_res"}, 32'(out_res), 32'd0);
    checkOutput({tag, "_idx"}, 32'(out_res_reg_idx), 32'd0);
    checkOutput({tag, "_instr"}, 32'(out_instr), 32'd0);
    checkOutput({tag, "_pc"}, 32'(out_pc), 32'd0);
    checkOutput({tag, "_req"}, 32'(dmem_req), 32'd0);
    checkOutput({tag, "_we"}, 32'(dmem_we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(dmem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(dmem_wdata), 32'd0);
    checkOutput({tag, "_stall"}, 32'(out_stall), 32'd0);
  endtask

  // Issue one instruction from IDLE; memory responds after 'waits' extra cycles
  task automatic runInstr(input logic [15:0] instr, input logic [11:0] pc, input logic [15:0] res,
                          input logic [3:0] idx, input logic wr, input logic ld, input logic st,
                          input logic [15:0] sdata, input int waits, input logic [15:0] rdata);
    applyStimulus(1'b1, instr, pc, res, idx, wr, ld, st, sdata);
    checkOutput("stall_pre", 32'(out_stall), 32'd0);
    tick();
    if (!(ld || st)) begin
      checkOutput("alu_valid", 32'(out_valid), 32'd1);
      checkOutput("alu_res", 32'(out_res), 32'(res));
      checkOutput("alu_idx", 32'(out_res_reg_idx), 32'(idx));
      checkOutput("alu_act", 32'(out_act_write_res_to_reg), 32'(wr));
      checkOutput("alu_instr", 32'(out_instr), 32'(instr));
      checkOutput("alu_pc", 32'(out_pc), 32'(pc));
      checkOutput("alu_req", 32'(dmem_req), 32'd0);
    end else begin
      checkOutput("mem_valid0", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 16'($urandom), 12'($urandom), 16'($urandom), 4'($urandom),
                    1'b1, 1'b0, 1'b1, 16'($urandom));
      for (int w = 0; w <= waits; w++) begin
        checkOutput("wait_stall", 32'(out_stall), 32'd1);
        checkOutput("wait_req", 32'(dmem_req), 32'd1);
        checkOutput("wait_we", 32'(dmem_we), 32'(st && !ld));
        checkOutput("wait_addr", 32'(dmem_addr), 32'(res[11:0]));
        checkOutput("wait_wdata", 32'(dmem_wdata), 32'(sdata));
        dmem_ack = (w == waits);
        dmem_rdata = (w == waits) ? rdata : 16'($urandom);
        tick();
      end
      dmem_ack = 1'b0;
      checkOutput("mem_valid", 32'(out_valid), 32'd1);
      checkOutput("mem_res", 32'(out_res), 32'(expectRes(ld, res, rdata)));
      checkOutput("mem_act", 32'(out_act_write_res_to_reg), 32'(expectWrite(ld, st, wr)));
      checkOutput("mem_idx", 32'(out_res_reg_idx), 32'(idx));
      checkOutput("mem_instr", 32'(out_instr), 32'(instr));
      checkOutput("mem_pc", 32'(out_pc), 32'(pc));
      checkOutput("mem_req", 32'(dmem_req), 32'd0);
      checkOutput("mem_stall", 32'(out_stall), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    tick();
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_act", 32'(out_act_write_res_to_reg), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    checkAllZero("reset");
`ifdef MEMORY_ACCESS_TIMEOUT_EN
    checkOutput("bus_err_reset", 32'(out_bus_error), 32'd0);
`endif
    reset = 1'b0;

    runInstr(16'hA001, 12'h010, 16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000);
    idleCycle();

    runInstr(16'hB002, 12'h011, 16'hF0A5, 4'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 16'hBEEF);
    idleCycle();

    runInstr(16'hC003, 12'h012, 16'h0010, 4'd6, 1'b0, 1'b0, 1'b1, 16'h5555, 3, 16'h0000);
    idleCycle();

    // Load and store together behave as a load
    runInstr(16'hC004, 12'h013, 16'h0777, 4'd2, 1'b1, 1'b1, 1'b1, 16'h9999, 1, 16'h4242);
    idleCycle();

    // Ack while idle must not produce anything
    dmem_ack = 1'b1;
    dmem_rdata = 16'hDEAD;
    tick();
    dmem_ack = 1'b0;
    checkOutput("idle_ack_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_ack_req", 32'(dmem_req), 32'd0);

    // Load, then an ALU op held by upstream through the stall
    applyStimulus(1'b1, 16'hD005, 12'h020, 16'h0044, 4'd8, 1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b1, 16'hD006, 12'h021, 16'h7777, 4'd9, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("b2b_stall", 32'(out_stall), 32'd1);
    dmem_ack = 1'b1;
    dmem_rdata = 16'h3C3C;
    tick();
    dmem_ack = 1'b0;
    checkOutput("b2b_load_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_load_res", 32'(out_res), 32'h3C3C);
    checkOutput("b2b_load_pc", 32'(out_pc), 32'h020);
    checkOutput("b2b_stall_low", 32'(out_stall), 32'd0);
    tick();
    checkOutput("b2b_alu_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_alu_res", 32'(out_res), 32'h7777);
    checkOutput("b2b_alu_pc", 32'(out_pc), 32'h021);
    idleCycle();

    // Reset in the second WAIT cycle, then a late ack
    applyStimulus(1'b1, 16'hE007, 12'h030, 16'h0123, 4'd7, 1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    in_valid = 1'b0;
    checkOutput("rst_wait1", 32'(out_stall), 32'd1);
    tick();
    checkOutput("rst_wait2", 32'(out_stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkAllZero("rst_wait");
    dmem_ack = 1'b1;
    dmem_rdata = 16'hFFFF;
    tick();
    dmem_ack = 1'b0;
    checkAllZero("late_ack");

    // Randomized traffic; 3 extra waits coincides with the timeout edge when enabled
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      runInstr(16'($urandom), 12'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
               kind == 1 || kind == 3, kind >= 2, 16'($urandom),
               int'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 1) == 1) idleCycle();
    end

`ifdef MEMORY_ACCESS_TIMEOUT_EN
    checkOutput("bus_err_clear", 32'(out_bus_error), 32'd0);
    applyStimulus(1'b1, 16'hF008, 12'h040, 16'h0ABC, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    in_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      checkOutput("to_stall", 32'(out_stall), 32'd1);
      tick();
    end
    checkOutput("to_valid", 32'(out_valid), 32'd1);
    checkOutput("to_act", 32'(out_act_write_res_to_reg), 32'd0);
    checkOutput("to_req", 32'(dmem_req), 32'd0);
    checkOutput("to_err", 32'(out_bus_error), 32'd1);
    idleCycle();
    runInstr(16'hF009, 12'h041, 16'h1111, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000);
    checkOutput("to_err_sticky", 32'(out_bus_error), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
